// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encodings and bus-wide defaults.
package bus_arbiter_rr_pkg;

  localparam int unsigned DEF_NUM_MASTERS = 4;
  localparam int unsigned DEF_IDX_W       = 2;
  localparam int unsigned DEF_MAX_HOLD    = 4;
  localparam int unsigned DEF_CNT_W       = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first request after ptr, circularly,
// optionally ignoring one master (the current owner).
module bus_arbiter_rr_pick #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic [IDX_W-1:0]       mask_idx,
  input  logic                   mask_en,
  output logic [NUM_MASTERS-1:0] win,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   any
);

  localparam int unsigned SH_W = IDX_W + 1;
  localparam logic [SH_W-1:0] N_S = SH_W'(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]   req_m;
  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic [SH_W-1:0]          start;
  logic [SH_W-1:0]          ofs;
  logic [SH_W-1:0]          sum;

  // Drop the excluded master, then rotate so the search origin lands at bit 0.
  always_comb begin
    req_m = req;
    if (mask_en) req_m[mask_idx] = 1'b0;
    start = SH_W'(ptr) + SH_W'(1);
    if (start >= N_S) start = start - N_S;
    dbl = {req_m, req_m};
    rot = NUM_MASTERS'(dbl >> start);
  end

  // Lowest set bit of the rotated vector is the winner.
  always_comb begin
    ofs = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) ofs = SH_W'(i);
    end
    any = |rot;
    sum = start + ofs;
    if (sum >= N_S) sum = sum - N_S;
    win_idx = IDX_W'(sum);
    win = '0;
    if (any) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin bus arbiter with registered one-hot grant and a bounded
// tenure under contention.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned IDX_W       = DEF_IDX_W,
  parameter int unsigned MAX_HOLD    = DEF_MAX_HOLD,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]       hold_q, hold_d;

  logic [NUM_MASTERS-1:0] pick_win;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   owner_req;
  logic                   take;

  // While owned, last_ptr equals the owner, so one picker serves both handover and preemption.
  bus_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (last_ptr_q),
    .mask_idx (idx_q),
    .mask_en  (state_q == ST_OWNED),
    .win      (pick_win),
    .win_idx  (pick_idx),
    .any      (pick_any)
  );

  assign owner_req = req[idx_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    last_ptr_d = last_ptr_q;
    hold_d     = hold_q;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) take = 1'b1;
      end
      ST_OWNED: begin
        if (!owner_req) begin
          // Release wins over preemption; hand over with no idle cycle when possible.
          if (pick_any) begin
            take = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else if (HOLD_EN && (hold_q == HOLD_LAST) && pick_any) begin
          take = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (take) begin
      state_d    = ST_OWNED;
      grant_d    = pick_win;
      idx_d      = pick_idx;
      valid_d    = 1'b1;
      last_ptr_d = pick_idx;
      hold_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      last_ptr_q <= PTR_RST;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      last_ptr_q <= last_ptr_d;
      hold_q     <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: one instance with MAX_HOLD=4, one with MAX_HOLD=0.
module tb_bus_arbiter_rr;

  typedef struct {
    logic [3:0] ga;
    logic [3:0] gb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] idx_a, idx_b;
  logic       valid_a, valid_b;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.NUM_MASTERS(4), .IDX_W(2), .MAX_HOLD(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req_a),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .IDX_W(2), .MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req_b),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Monitor: the expectation pushed with a stimulus applies just after the next rising edge.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("grant_a", int'(grant_a), int'(e.ga));
      check("valid_a", int'(valid_a), int'(|e.ga));
      if (|e.ga) check("idx_a", int'(idx_a), oh_idx(e.ga));
      check("grant_b", int'(grant_b), int'(e.gb));
      check("valid_b", int'(valid_b), int'(|e.gb));
      if (|e.gb) check("idx_b", int'(idx_b), oh_idx(e.gb));
    end
  end

  task automatic step(input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] ea, input logic [3:0] eb);
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    q.push_back('{ga: ea, gb: eb});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    repeat (3) @(negedge clk);
    check("rst_grant_a", int'(grant_a), 0);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_idx_a",   int'(idx_a),   0);
    check("rst_grant_b", int'(grant_b), 0);
    reset_n = 1'b1;

    // Single request, then release.
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Full contention on dut (4 cycles each); dut0 without a hold limit keeps master 0.
    do_reset();
    for (int k = 0; k < 19; k++)
      step(4'b1111, 4'b0011, 4'(1 << ((k / 4) % 4)), 4'b0001);
    step(4'b1111, 4'b0010, 4'b0001, 4'b0010);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Lone owner is never preempted.
    for (int k = 0; k < 20; k++) step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Two-master regression; master 1 saturated its counter alone, so contention preempts at once.
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) step(4'b0010, 4'b0000, 4'b0010, 4'b0000);
    for (int k = 0; k < 4; k++) step(4'b0011, 4'b0000, 4'b0001, 4'b0000);
    for (int k = 0; k < 4; k++) step(4'b0011, 4'b0000, 4'b0010, 4'b0000);
    step(4'b0011, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Async reset mid-grant, then priority restarts at master 0.
    step(4'b0100, 4'b0010, 4'b0100, 4'b0010);
    step(4'b0100, 4'b0010, 4'b0100, 4'b0010);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    #1;
    check("async_grant_a", int'(grant_a), 0);
    check("async_valid_a", int'(valid_a), 0);
    check("async_grant_b", int'(grant_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(4'b1001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b1001, 4'b0000, 4'b1000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    t = 0;
    while (q.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
